// File: rtl/roi_pad_axis.sv
// roi_pad_axis: rebuilds a full WIDTH x HEIGHT AXI-Stream frame from a raster-order ROI stream.
// ROI pixels land inside the inclusive rectangle spanned by two corners; all other
// positions carry BG_VALUE.
// Optional build macro: ROI_BORDER_EN draws an all-ones 1-pixel ring around a valid ROI.
module roi_pad_axis #(
  parameter int unsigned            WIDTH     = 800,
  parameter int unsigned            HEIGHT    = 600,
  parameter int unsigned            BIT_DATA  = 8,
  parameter int unsigned            BIT_COORD = 32,
  parameter logic [BIT_DATA-1:0]    BG_VALUE  = '0
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 start_i,
  input  logic [BIT_COORD-1:0] xy_0_i,
  input  logic [BIT_COORD-1:0] xy_1_i,
  input  logic [BIT_DATA-1:0]  s_tdata_i,
  input  logic                 s_tvalid_i,
  input  logic                 s_tlast_i,
  output logic                 s_tready_o,
  output logic [BIT_DATA-1:0]  m_tdata_o,
  output logic                 m_tvalid_o,
  output logic                 m_tlast_o,
  output logic                 m_tuser_o,
  input  logic                 m_tready_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       cnt_x_q, cnt_x_d;
  logic [YW-1:0]       cnt_y_q, cnt_y_d;
  logic [10:0]         xmin_q, xmin_d, xmax_q, xmax_d;
  logic [9:0]          ymin_q, ymin_d, ymax_q, ymax_d;
  logic                roi_ok_q, roi_ok_d;
  logic                roi_done_q, roi_done_d;
  logic                gen_done_q, gen_done_d;
  logic [BIT_DATA-1:0] m_tdata_q, m_tdata_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                m_tlast_q, m_tlast_d;
  logic                m_tuser_q, m_tuser_d;
  logic                err_q, err_d;

  // Corner fields and their normalised rectangle
  logic [10:0] x0, x1, xmin_n, xmax_n;
  logic [9:0]  y0, y1, ymin_n, ymax_n;
  logic        roi_bad_n;

  assign x0     = xy_0_i[26:16];
  assign x1     = xy_1_i[26:16];
  assign y0     = xy_0_i[9:0];
  assign y1     = xy_1_i[9:0];
  assign xmin_n = (x0 < x1) ? x0 : x1;
  assign xmax_n = (x0 < x1) ? x1 : x0;
  assign ymin_n = (y0 < y1) ? y0 : y1;
  assign ymax_n = (y0 < y1) ? y1 : y0;
  assign roi_bad_n = (32'(xmax_n) >= 32'(WIDTH)) || (32'(ymax_n) >= 32'(HEIGHT));

  logic unused_xy;
  assign unused_xy = ^{xy_0_i[BIT_COORD-1:27], xy_0_i[15:10],
                       xy_1_i[BIT_COORD-1:27], xy_1_i[15:10]};

  // Position classification, done in 32 bits so the ring bounds cannot wrap
  logic [31:0] px, py, xmin32, xmax32, ymin32, ymax32;
  logic        in_rect, in_roi, at_last_roi, at_frame_end, out_free, active;
  logic [BIT_DATA-1:0] fill_val;

  assign px     = 32'(cnt_x_q);
  assign py     = 32'(cnt_y_q);
  assign xmin32 = 32'(xmin_q);
  assign xmax32 = 32'(xmax_q);
  assign ymin32 = 32'(ymin_q);
  assign ymax32 = 32'(ymax_q);

  assign in_rect      = (px >= xmin32) && (px <= xmax32) && (py >= ymin32) && (py <= ymax32);
  assign in_roi       = roi_ok_q && in_rect;
  assign at_last_roi  = (px == xmax32) && (py == ymax32);
  assign at_frame_end = (cnt_x_q == XLast) && (cnt_y_q == YLast);
  assign out_free     = !m_tvalid_q || m_tready_i;
  assign active       = (state_q == StActive);

`ifdef ROI_BORDER_EN
  logic in_ring;
  assign in_ring  = roi_ok_q && !in_rect &&
                    (px + 32'd1 >= xmin32) && (px <= xmax32 + 32'd1) &&
                    (py + 32'd1 >= ymin32) && (py <= ymax32 + 32'd1);
  assign fill_val = in_ring ? '1 : BG_VALUE;
`else
  assign fill_val = BG_VALUE;
`endif

  assign s_tready_o = active && in_roi && !roi_done_q && !gen_done_q && out_free;

  // Next-state: coordinate latch on start, raster walk and output-register load in ACTIVE
  always_comb begin
    logic                load;
    logic [BIT_DATA-1:0] load_data;
    state_d     = state_q;
    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    roi_ok_d    = roi_ok_q;
    roi_done_d  = roi_done_q;
    gen_done_d  = gen_done_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;
    err_d       = 1'b0;
    load        = 1'b0;
    load_data   = fill_val;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StActive;
          xmin_d     = xmin_n;
          xmax_d     = xmax_n;
          ymin_d     = ymin_n;
          ymax_d     = ymax_n;
          roi_ok_d   = !roi_bad_n;
          err_d      = roi_bad_n;
          cnt_x_d    = '0;
          cnt_y_d    = '0;
          roi_done_d = 1'b0;
          gen_done_d = 1'b0;
        end
      end
      StActive: begin
        if (out_free) begin
          if (m_tvalid_q && m_tlast_q) begin
            // Frame-last beat is being accepted this cycle
            state_d    = StIdle;
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            m_tuser_d  = 1'b0;
          end else if (gen_done_q) begin
            m_tvalid_d = 1'b0;
          end else if (in_roi && !roi_done_q) begin
            if (s_tvalid_i) begin
              load      = 1'b1;
              load_data = s_tdata_i;
              // tlast must coincide exactly with the bottom-right ROI pixel
              if (s_tlast_i != at_last_roi) err_d = 1'b1;
              if (s_tlast_i || at_last_roi) roi_done_d = 1'b1;
            end else begin
              m_tvalid_d = 1'b0;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = load_data;
      m_tuser_d  = (cnt_x_q == '0) && (cnt_y_q == '0);
      m_tlast_d  = at_frame_end;
      if (cnt_x_q == XLast) begin
        cnt_x_d = '0;
        cnt_y_d = (cnt_y_q == YLast) ? '0 : cnt_y_q + YW'(1);
      end else begin
        cnt_x_d = cnt_x_q + XW'(1);
      end
      if (at_frame_end) gen_done_d = 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q    <= StIdle;
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      roi_ok_q   <= 1'b0;
      roi_done_q <= 1'b0;
      gen_done_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymin_q     <= ymin_d;
      ymax_q     <= ymax_d;
      roi_ok_q   <= roi_ok_d;
      roi_done_q <= roi_done_d;
      gen_done_q <= gen_done_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      err_q      <= err_d;
    end
  end

  assign m_tdata_o  = m_tdata_q;
  assign m_tvalid_o = m_tvalid_q;
  assign m_tlast_o  = m_tlast_q;
  assign m_tuser_o  = m_tuser_q;
  assign busy_o     = active;
  assign err_o      = err_q;

endmodule

// File: tb/tb_roi_pad_axis.sv
// Directed bench for roi_pad_axis on an 8x4 frame with zero background.
module tb_roi_pad_axis;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        arst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] xy_0_i = '0;
  logic [31:0] xy_1_i = '0;
  logic [7:0]  s_tdata_i = '0;
  logic        s_tvalid_i = 1'b0;
  logic        s_tlast_i = 1'b0;
  logic        s_tready_o;
  logic [7:0]  m_tdata_o;
  logic        m_tvalid_o;
  logic        m_tlast_o;
  logic        m_tuser_o;
  logic        m_tready_i = 1'b1;
  logic        busy_o;
  logic        err_o;

  int vec_cnt = 0;
  int miss_cnt = 0;

  roi_pad_axis #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .BIT_DATA  (8),
    .BIT_COORD (32),
    .BG_VALUE  (8'h00)
  ) dut (
    .clk_i      (clk),
    .arst_i     (arst_i),
    .start_i    (start_i),
    .xy_0_i     (xy_0_i),
    .xy_1_i     (xy_1_i),
    .s_tdata_i  (s_tdata_i),
    .s_tvalid_i (s_tvalid_i),
    .s_tlast_i  (s_tlast_i),
    .s_tready_o (s_tready_o),
    .m_tdata_o  (m_tdata_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tlast_o  (m_tlast_o),
    .m_tuser_o  (m_tuser_o),
    .m_tready_i (m_tready_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack_xy(input int x, input int y);
    return ((32'(x) & 32'h7ff) << 16) | (32'(y) & 32'h3ff);
  endfunction

  // Runs one frame. Input pixels are 0x11, 0x12, ... in order; n_acc of them are expected to be
  // consumed and placed on successive ROI positions, remaining ROI positions read as zero.
  task automatic run_frame(input string name, input int x0, input int y0, input int x1,
                           input int y1, input int n_in, input int tlast_at, input bit gaps,
                           input bit stalls, input int abort_at, input int n_acc,
                           input bit roi_ok, input int exp_err);
    logic [7:0] exp_d[N];
    int xmin, xmax, ymin, ymax, k;
    int nb, src, errs, bub, exp_bub, mpos, macc;
    bit held, done, mroi;
    logic [7:0] hd;
    logic hu, hl;
    xmin = (x0 < x1) ? x0 : x1;
    xmax = (x0 < x1) ? x1 : x0;
    ymin = (y0 < y1) ? y0 : y1;
    ymax = (y0 < y1) ? y1 : y0;
    k = 0;
    for (int p = 0; p < N; p++) begin
      exp_d[p] = 8'h00;
      if (roi_ok && (p % W) >= xmin && (p % W) <= xmax && (p / W) >= ymin && (p / W) <= ymax)
      begin
        if (k < n_acc) exp_d[p] = 8'h11 + 8'(k);
        k++;
      end
    end
    nb = 0; src = 0; errs = 0; bub = 0; exp_bub = 0; mpos = 0; macc = 0;
    held = 1'b0; done = 1'b0; hd = '0; hu = 1'b0; hl = 1'b0;

    @(negedge clk);
    xy_0_i = pack_xy(x0, y0);
    xy_1_i = pack_xy(x1, y1);
    start_i = 1'b1;
    s_tvalid_i = 1'b0;
    m_tready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;

    for (int i = 0; i < 400 && !done; i++) begin
      s_tvalid_i = (src < n_in) && !(gaps && ($urandom_range(0, 2) == 0));
      s_tdata_i  = 8'h11 + 8'(src);
      s_tlast_i  = (src == tlast_at);
      m_tready_i = stalls ? ($urandom_range(0, 9) >= 3) : 1'b1;
      #1;
      if (i == 0) begin
        vec_cnt++;
        if (busy_o !== 1'b1) begin
          miss_cnt++;
          $display("FAIL %s busy_after_start got %b exp 1", name, busy_o);
        end
        vec_cnt++;
        if (err_o !== !roi_ok) begin
          miss_cnt++;
          $display("FAIL %s err_after_start got %b exp %b", name, err_o, !roi_ok);
        end
      end
      if (err_o) errs++;
      if (s_tready_o && m_tvalid_o && !m_tready_i) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL %s tready_during_stall got 1 exp 0 (cycle %0d)", name, i);
      end
      if (!roi_ok && s_tready_o) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL %s tready_invalid_roi got 1 exp 0 (cycle %0d)", name, i);
      end
      if (held) begin
        vec_cnt++;
        if ({m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o} !== {1'b1, hd, hu, hl}) begin
          miss_cnt++;
          $display("FAIL %s hold_stable got %b/%h/%b/%b exp 1/%h/%b/%b", name, m_tvalid_o,
                   m_tdata_o, m_tuser_o, m_tlast_o, hd, hu, hl);
        end
      end
      // Pixel-accept model assuming the output is never stalled
      if (mpos < N) begin
        mroi = roi_ok && (mpos % W) >= xmin && (mpos % W) <= xmax &&
               (mpos / W) >= ymin && (mpos / W) <= ymax && (macc < n_acc);
        if (mroi && !s_tvalid_i) begin
          exp_bub++;
        end else begin
          if (mroi) macc++;
          mpos++;
        end
      end
      if (i >= 1 && !m_tvalid_o && nb < N) bub++;
      if (s_tvalid_i && s_tready_o) src++;
      if (m_tvalid_o && m_tready_i && nb < N) begin
        vec_cnt++;
        if (m_tdata_o !== exp_d[nb]) begin
          miss_cnt++;
          $display("FAIL %s beat %0d data got %h exp %h", name, nb, m_tdata_o, exp_d[nb]);
        end
        vec_cnt++;
        if (m_tuser_o !== (nb == 0)) begin
          miss_cnt++;
          $display("FAIL %s beat %0d tuser got %b exp %b", name, nb, m_tuser_o, nb == 0);
        end
        vec_cnt++;
        if (m_tlast_o !== (nb == N - 1)) begin
          miss_cnt++;
          $display("FAIL %s beat %0d tlast got %b exp %b", name, nb, m_tlast_o, nb == N - 1);
        end
        nb++;
      end
      held = m_tvalid_o && !m_tready_i;
      hd = m_tdata_o; hu = m_tuser_o; hl = m_tlast_o;
      if (nb == abort_at) return;
      if (nb == N) done = 1'b1;
      @(negedge clk);
    end

    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    vec_cnt++;
    if (!done) begin
      miss_cnt++;
      $display("FAIL %s frame_timeout got %0d beats exp %0d", name, nb, N);
    end
    #1;
    vec_cnt++;
    if ({busy_o, m_tvalid_o} !== 2'b00) begin
      miss_cnt++;
      $display("FAIL %s idle_after_frame got busy=%b valid=%b exp 0/0", name, busy_o, m_tvalid_o);
    end
    vec_cnt++;
    if (errs != exp_err) begin
      miss_cnt++;
      $display("FAIL %s err_pulses got %0d exp %0d", name, errs, exp_err);
    end
    vec_cnt++;
    if (src != n_acc) begin
      miss_cnt++;
      $display("FAIL %s pixels_consumed got %0d exp %0d", name, src, n_acc);
    end
    if (!stalls) begin
      vec_cnt++;
      if (bub != exp_bub) begin
        miss_cnt++;
        $display("FAIL %s bubble_cycles got %0d exp %0d", name, bub, exp_bub);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    vec_cnt++;
    if ({m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o, s_tready_o, busy_o, err_o} !== '0) begin
      miss_cnt++;
      $display("FAIL %s outputs got v=%b d=%h l=%b u=%b rdy=%b busy=%b err=%b exp all 0", name,
               m_tvalid_o, m_tdata_o, m_tlast_o, m_tuser_o, s_tready_o, busy_o, err_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    arst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    arst_i = 1'b0;
  endtask

  task automatic test_basic();
    run_frame("basic", 2, 1, 4, 2, 6, 5, 1'b0, 1'b0, -1, 6, 1'b1, 0);
  endtask

  task automatic test_swapped_gaps();
    run_frame("swapped_gaps", 4, 2, 2, 1, 6, 5, 1'b1, 1'b0, -1, 6, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 2, 1, 4, 2, 6, 5, 1'b1, 1'b1, -1, 6, 1'b1, 0);
  endtask

  task automatic test_early_tlast();
    run_frame("early_tlast", 0, 0, 1, 0, 2, 0, 1'b0, 1'b0, -1, 1, 1'b1, 1);
  endtask

  task automatic test_missing_tlast();
    // ROI ends at the frame's bottom-right: last ROI pixel and frame-last beat coincide
    run_frame("missing_tlast", 5, 3, 7, 3, 4, -1, 1'b0, 1'b0, -1, 3, 1'b1, 1);
  endtask

  task automatic test_invalid_roi();
    run_frame("invalid_roi", 0, 0, 8, 1, 3, 2, 1'b0, 1'b0, -1, 0, 1'b0, 1);
  endtask

  task automatic test_midframe_reset();
    run_frame("midframe_pre", 2, 1, 4, 2, 6, 5, 1'b0, 1'b0, 15, 6, 1'b1, 0);
    arst_i = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("midframe_reset");
    arst_i = 1'b0;
    s_tvalid_i = 1'b0;
    s_tlast_i = 1'b0;
    run_frame("after_reset", 2, 1, 4, 2, 6, 5, 1'b0, 1'b0, -1, 6, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swapped_gaps();
    test_backpressure();
    test_early_tlast();
    test_missing_tlast();
    test_invalid_roi();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
